// File: rtl/cart_button.sv
// Cart button conditioner: synchronises and debounces the raw pin, then
// classifies accepted presses into press/release/click/long-press strobes.
module cart_button #(
  parameter int DEBOUNCE_CYCLES   = 1_000_000,
  parameter int LONG_PRESS_CYCLES = 100_000_000,
  parameter bit ACTIVE_LOW        = 1'b1
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_button,
  output logic o_pressed,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_long_press
);

  localparam int   DW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int   HW       = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic INACTIVE = ACTIVE_LOW;
  localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);

  typedef enum logic [1:0] {IDLE, PRESSED, HELD} state_t;

  logic [1:0]    sync_q;
  logic          s_btn;
  logic [DW-1:0] deb_cnt;
  logic          accept;
  state_t        state, state_d;
  logic [HW-1:0] hold_cnt, hold_d;
  logic          press_d, release_d, click_d, long_d;

  // Sync flops reset to the idle pin level so reset exit never looks like a press.
  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= {2{INACTIVE}};
    else         sync_q <= {sync_q[0], i_button};
  end

  assign s_btn  = sync_q[1] ^ INACTIVE;
  assign accept = (s_btn != o_pressed) && (deb_cnt == DEB_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset)                         deb_cnt <= '0;
    else if (s_btn == o_pressed || accept) deb_cnt <= '0;
    else                                 deb_cnt <= deb_cnt + 1'b1;
  end

  always_comb begin
    state_d   = state;
    hold_d    = hold_cnt;
    press_d   = 1'b0;
    release_d = 1'b0;
    click_d   = 1'b0;
    long_d    = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_d = PRESSED;
        press_d = 1'b1;
        hold_d  = '0;
      end
      PRESSED: begin
        // A release accepted on the threshold cycle wins over the long press.
        if (accept) begin
          state_d   = IDLE;
          release_d = 1'b1;
          click_d   = 1'b1;
        end else begin
          hold_d = hold_cnt + 1'b1;
          if (hold_d == HOLD_MAX) begin
            state_d = HELD;
            long_d  = 1'b1;
          end
        end
      end
      HELD: if (accept) begin
        state_d   = IDLE;
        release_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      o_pressed    <= 1'b0;
      o_press      <= 1'b0;
      o_release    <= 1'b0;
      o_click      <= 1'b0;
      o_long_press <= 1'b0;
    end else begin
      state        <= state_d;
      hold_cnt     <= hold_d;
      o_pressed    <= (state_d != IDLE);
      o_press      <= press_d;
      o_release    <= release_d;
      o_click      <= click_d;
      o_long_press <= long_d;
    end
  end

endmodule

// File: tb/tb_cart_button.sv
// Randomised bench for cart_button: both pin polarities run side by side
// against a sample-window / timestamp reference model.
module tb_cart_button;
  localparam int D = 4;
  localparam int L = 20;
  localparam int MAXE = 8192;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pin_lo = 1'b1, pin_hi = 1'b0;
  logic a_pressed, a_press, a_release, a_click, a_long;
  logic b_pressed, b_press, b_release, b_click, b_long;

  always #5 clk = ~clk;

  cart_button #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b1)) u_lo (
    .i_clk(clk), .i_reset(rst), .i_button(pin_lo),
    .o_pressed(a_pressed), .o_press(a_press), .o_release(a_release),
    .o_click(a_click), .o_long_press(a_long));

  cart_button #(.DEBOUNCE_CYCLES(D), .LONG_PRESS_CYCLES(L), .ACTIVE_LOW(1'b0)) u_hi (
    .i_clk(clk), .i_reset(rst), .i_button(pin_hi),
    .o_pressed(b_pressed), .o_press(b_press), .o_release(b_release),
    .o_click(b_click), .o_long_press(b_long));

  int n_vec = 0;
  int n_err = 0;
  int edge_n = 0;
  bit samp [0:MAXE-1];
  bit deb = 1'b0, long_done = 1'b0;
  int press_at = 0, last_rst = 0;
  logic [4:0] exp_o;

  task automatic chk(input string tag, input logic [4:0] got, input logic [4:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s edge %0d got %b exp %b (pressed,press,release,click,long)",
               tag, edge_n, got, exp);
    end
  endtask

  // Reference: the level flips when the D most recent synchronised samples
  // (pin as sampled two edges earlier) all disagree with it, none predating reset.
  task automatic model(input bit pressed, input bit r);
    bit acc;
    exp_o = '0;
    samp[edge_n] = pressed;
    if (r) begin
      samp[edge_n] = 1'b0;
      samp[edge_n-1] = 1'b0;
      deb = 1'b0;
      long_done = 1'b0;
      last_rst = edge_n;
      return;
    end
    acc = (edge_n - D + 1 > last_rst);
    for (int j = 0; j < D; j++)
      if (samp[edge_n-2-j] == deb) acc = 1'b0;
    if (acc && !deb) begin
      deb = 1'b1; press_at = edge_n; long_done = 1'b0; exp_o[3] = 1'b1;
    end else if (acc) begin
      deb = 1'b0; exp_o[2] = 1'b1; exp_o[1] = !long_done;
    end else if (deb && !long_done && edge_n - press_at == L) begin
      long_done = 1'b1; exp_o[0] = 1'b1;
    end
    exp_o[4] = deb;
  endtask

  task automatic step(input bit pressed, input bit r);
    @(negedge clk);
    pin_lo = ~pressed;
    pin_hi = pressed;
    rst = r;
    @(posedge clk);
    edge_n++;
    #1;
    model(pressed, r);
    chk("act_low",  {a_pressed, a_press, a_release, a_click, a_long}, exp_o);
    chk("act_high", {b_pressed, b_press, b_release, b_click, b_long}, exp_o);
  endtask

  task automatic hold(input bit pressed, input int n);
    for (int i = 0; i < n; i++) step(pressed, 1'b0);
  endtask

  initial begin
    for (int i = 0; i < MAXE; i++) samp[i] = 1'b0;
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    hold(1'b0, 50);                          // idle: nothing ever fires
    hold(1'b1, 40); hold(1'b0, 20);          // long press then release
    hold(1'b1, 14); hold(1'b0, 20);          // click
    hold(1'b1, 3); hold(1'b0, 1); hold(1'b1, 3); hold(1'b0, 20); // glitches
    hold(1'b1, 20); hold(1'b0, 20);          // release coincides with threshold
    hold(1'b1, 35); step(1'b1, 1'b1); hold(1'b1, 12); hold(1'b0, 20); // reset mid-hold
    for (int s = 0; s < 300; s++) begin
      int len;
      case ($urandom_range(0, 3))
        0: len = $urandom_range(1, 3);
        1: len = $urandom_range(D, D + 3);
        2: len = $urandom_range(L - 2, L + 2);
        default: len = $urandom_range(8, 35);
      endcase
      if ($urandom_range(0, 19) == 0) step($urandom_range(0, 1) == 1, 1'b1);
      if (edge_n + len + 2 < MAXE) hold(s[0], len);
    end
    hold(1'b0, 12);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
